// File: rtl/layer_out_serializer.sv
// Captures a full layer of neuron activations in one cycle and replays them
// one per clock as the serial input stream of the next fully connected layer.
module layer_out_serializer #(
  parameter int numNeurons = 30,
  parameter int dataWidth  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [numNeurons*dataWidth-1:0]  in_data,
  input  logic [numNeurons-1:0]            in_valid,
  input  logic                             err_clear,
  output logic [dataWidth-1:0]             out_data,
  output logic                             out_valid,
  output logic                             out_last,
  output logic                             busy,
  output logic                             mismatch_err,
  output logic                             overrun_err
);

  localparam int                CNT_W    = $clog2(numNeurons);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(numNeurons - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       count_nxt;
  logic [dataWidth-1:0]   buf_q [numNeurons];
  logic [dataWidth-1:0]   buf_d [numNeurons];
  logic [dataWidth-1:0]   out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   out_last_q, out_last_d;
  logic                   busy_q, busy_d;
  logic                   mismatch_q, mismatch_d;
  logic                   overrun_q, overrun_d;

  logic cap;
  logic partial;
  logic at_last;
  logic accept;
  logic overrun_evt;

  // A capture is taken from IDLE, or on the edge that retires the last element
  // so back-to-back bursts stream without a gap; anywhere else it is an overrun.
  always_comb begin
    cap         = &in_valid;
    partial     = (|in_valid) & ~cap;
    at_last     = (state_q == SHIFT) && (count_q == LAST_IDX);
    accept      = cap && ((state_q == IDLE) || at_last);
    overrun_evt = cap && (state_q == SHIFT) && !at_last;
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d     = state_q;
    count_d     = count_q;
    count_nxt   = count_q + 1'b1;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    buf_d       = buf_q;

    if (accept) begin
      for (int i = 0; i < numNeurons; i++) begin
        buf_d[i] = in_data[i*dataWidth +: dataWidth];
      end
      state_d     = SHIFT;
      count_d     = '0;
      out_data_d  = in_data[0 +: dataWidth];
      out_valid_d = 1'b1;
      out_last_d  = 1'b0;
      busy_d      = 1'b1;
    end else if (state_q == SHIFT) begin
      if (at_last) begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        busy_d      = 1'b0;
      end else begin
        count_d     = count_nxt;
        out_data_d  = buf_q[count_nxt];
        out_last_d  = (count_nxt == LAST_IDX);
      end
    end

    // Setting beats clearing when both happen on the same edge.
    mismatch_d = partial     | (mismatch_q & ~err_clear);
    overrun_d  = overrun_evt | (overrun_q  & ~err_clear);
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      mismatch_q  <= mismatch_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the capture buffer has no reset; it is always loaded by an accepted
  // capture before any element of it reaches the output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_q <= buf_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign busy         = busy_q;
  assign mismatch_err = mismatch_q;
  assign overrun_err  = overrun_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Bench for layer_out_serializer: directed scenarios plus random stimulus
// compared cycle by cycle against a queue-based reference model.
module tb_layer_out_serializer;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int NB = 30;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            err_clear = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_valid = '0;
  logic [DW-1:0]   out_data;
  logic            out_valid, out_last, busy, mismatch_err, overrun_err;

  logic [NB*DW-1:0] in_data30 = '0;
  logic [NB-1:0]    in_valid30 = '0;
  logic             err_clear30 = 1'b0;
  logic [DW-1:0]    out_data30;
  logic             out_valid30, out_last30, busy30, mismatch_err30, overrun_err30;

  layer_out_serializer #(.numNeurons(N), .dataWidth(DW)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .err_clear(err_clear), .out_data(out_data), .out_valid(out_valid),
    .out_last(out_last), .busy(busy), .mismatch_err(mismatch_err),
    .overrun_err(overrun_err)
  );

  layer_out_serializer #(.numNeurons(NB), .dataWidth(DW)) dut30 (
    .clk(clk), .rst(rst), .in_data(in_data30), .in_valid(in_valid30),
    .err_clear(err_clear30), .out_data(out_data30), .out_valid(out_valid30),
    .out_last(out_last30), .busy(busy30), .mismatch_err(mismatch_err30),
    .overrun_err(overrun_err30)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: remaining elements of the current burst after the one shown.
  logic [DW-1:0] m_stream[$];
  logic [DW-1:0] m_data  = '0;
  logic          m_valid = 1'b0, m_last = 1'b0, m_busy = 1'b0;
  logic          m_mis   = 1'b0, m_ovr  = 1'b0;

  function automatic logic [N*DW-1:0] pack4(input logic [DW-1:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [20:0] obs();
    return {out_valid, out_last, busy, mismatch_err, overrun_err, out_data};
  endfunction

  function automatic logic [20:0] model_vec();
    return {m_valid, m_last, m_busy, m_mis, m_ovr, m_data};
  endfunction

  // Drive one cycle of inputs, advance the model, clock, then settle.
  task automatic step(input logic r, input logic [N*DW-1:0] d, input logic [N-1:0] v,
                      input logic c);
    logic cap, part, ovr_evt;
    rst = r; in_data = d; in_valid = v; err_clear = c;
    cap = &v;
    part = (|v) && !cap;
    ovr_evt = 1'b0;
    if (r) begin
      m_stream.delete();
      m_data = '0; m_valid = 0; m_last = 0; m_busy = 0; m_mis = 0; m_ovr = 0;
    end else begin
      if (m_valid && m_stream.size() > 0) begin
        ovr_evt = cap;
        m_data  = m_stream.pop_front();
        m_last  = (m_stream.size() == 0);
      end else if (cap) begin
        m_stream.delete();
        for (int i = 0; i < N; i++) m_stream.push_back(d[i*DW +: DW]);
        m_data  = m_stream.pop_front();
        m_valid = 1'b1;
        m_last  = (m_stream.size() == 0);
        m_busy  = 1'b1;
      end else if (m_valid) begin
        m_valid = 1'b0; m_last = 1'b0; m_busy = 1'b0;
      end
      m_mis = part    | (m_mis & !c);
      m_ovr = ovr_evt | (m_ovr & !c);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = '0; err_clear = 1'b0;
  endtask

  task automatic test_reset();
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, pack4(1, 2, 3, 4), 4'hF, 1'b1);
    n_tests++;
    if (obs() !== 21'h0) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs(), 21'h0);
    end
    n_tests++;
    if (out_valid30 !== 1'b0 || busy30 !== 1'b0 || out_data30 !== '0) begin
      n_fail++; $display("FAIL reset_state30: got v=%b b=%b d=%h expected 0 0 0",
                         out_valid30, busy30, out_data30);
    end
  endtask

  task automatic test_basic();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(1'b0, pack4(1, 2, 3, 4), 4'hF, 1'b0);
      else        step(1'b0, '0, '0, 1'b0);
      n_tests++;
      if (obs() !== model_vec()) begin
        n_fail++; $display("FAIL basic_model cycle %0d: got %h expected %h", i, obs(), model_vec());
      end
      n_tests++;
      if (i < 4) begin
        if (out_data !== DW'(i + 1) || out_valid !== 1'b1 || busy !== 1'b1 ||
            out_last !== (i == 3)) begin
          n_fail++; $display("FAIL basic_elem %0d: got d=%h v=%b l=%b b=%b expected d=%h v=1 l=%b b=1",
                             i, out_data, out_valid, out_last, busy, DW'(i + 1), (i == 3));
        end
      end else if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || out_data !== 16'd4) begin
        n_fail++; $display("FAIL basic_idle: got d=%h v=%b l=%b b=%b expected d=4 v=0 l=0 b=0",
                           out_data, out_valid, out_last, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int valid_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 0)      step(1'b0, pack4(1, 2, 3, 4), 4'hF, 1'b0);
      else if (i == 4) step(1'b0, pack4(5, 6, 7, 8), 4'hF, 1'b0);
      else             step(1'b0, '0, '0, 1'b0);
      if (out_valid) valid_cnt++;
      n_tests++;
      if (obs() !== model_vec()) begin
        n_fail++; $display("FAIL b2b_model cycle %0d: got %h expected %h", i, obs(), model_vec());
      end
      if (i < 8) begin
        n_tests++;
        if (out_data !== DW'(i + 1) || out_valid !== 1'b1 || out_last !== (i == 3 || i == 7)) begin
          n_fail++; $display("FAIL b2b_elem %0d: got d=%h v=%b l=%b expected d=%h v=1 l=%b",
                             i, out_data, out_valid, out_last, DW'(i + 1), (i == 3 || i == 7));
        end
      end
    end
    n_tests++;
    if (valid_cnt != 8 || overrun_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_summary: got valid_cycles=%0d ovr=%b expected 8 0", valid_cnt, overrun_err);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      step(1'b0, pack4(1, 2, 3, 4), 4'hF, 1'b0);
      else if (i == 1) step(1'b0, pack4(9, 10, 11, 12), 4'hF, 1'b0);
      else if (i == 5) step(1'b0, '0, '0, 1'b1);
      else             step(1'b0, '0, '0, 1'b0);
      n_tests++;
      if (obs() !== model_vec()) begin
        n_fail++; $display("FAIL ovr_model cycle %0d: got %h expected %h", i, obs(), model_vec());
      end
      n_tests++;
      if (i < 4 && (out_data !== DW'(i + 1) || overrun_err !== (i >= 1))) begin
        n_fail++; $display("FAIL ovr_elem %0d: got d=%h ovr=%b expected d=%h ovr=%b",
                           i, out_data, overrun_err, DW'(i + 1), (i >= 1));
      end else if (i == 5 && (overrun_err !== 1'b0 || out_valid !== 1'b0)) begin
        n_fail++; $display("FAIL ovr_clear: got ovr=%b v=%b expected 0 0", overrun_err, out_valid);
      end
    end
  endtask

  task automatic test_mismatch();
    logic [3:0] vs [6] = '{4'b0111, 4'b0000, 4'b0000, 4'b0111, 4'b1010, 4'b0000};
    logic       cs [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       es [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(1'b0, pack4(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD), vs[i], cs[i]);
      n_tests++;
      if (obs() !== model_vec()) begin
        n_fail++; $display("FAIL mis_model cycle %0d: got %h expected %h", i, obs(), model_vec());
      end
      n_tests++;
      if (mismatch_err !== es[i] || out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL mis_flag %0d: got mis=%b v=%b b=%b expected mis=%b v=0 b=0",
                           i, mismatch_err, out_valid, busy, es[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] vals [4];
    step(1'b0, pack4(1, 2, 3, 4), 4'hF, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0);
    step(1'b1, pack4(7, 7, 7, 7), 4'hF, 1'b0);
    n_tests++;
    if (obs() !== 21'h0) begin
      n_fail++; $display("FAIL rst_mid: got %h expected %h", obs(), 21'h0);
    end
    for (int k = 0; k < 4; k++) vals[k] = DW'($urandom);
    for (int i = 0; i < 5; i++) begin
      if (i == 0) step(1'b0, pack4(vals[0], vals[1], vals[2], vals[3]), 4'hF, 1'b0);
      else        step(1'b0, '0, '0, 1'b0);
      n_tests++;
      if (obs() !== model_vec()) begin
        n_fail++; $display("FAIL rst_mid_model cycle %0d: got %h expected %h", i, obs(), model_vec());
      end
      if (i < 4) begin
        n_tests++;
        if (out_data !== vals[i] || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL rst_mid_elem %0d: got d=%h v=%b expected d=%h v=1",
                             i, out_data, out_valid, vals[i]);
        end
      end
    end
  endtask

  task automatic test_default_size();
    for (int i = 0; i < NB; i++) in_data30[i*DW +: DW] = DW'(i + 1);
    in_valid30 = '1;
    @(posedge clk); #1;
    in_valid30 = '0;
    for (int i = 0; i < NB; i++) begin
      n_tests++;
      if (out_valid30 !== 1'b1 || out_data30 !== DW'(i + 1) || out_last30 !== (i == NB - 1) ||
          busy30 !== 1'b1) begin
        n_fail++; $display("FAIL size30_elem %0d: got d=%h v=%b l=%b b=%b expected d=%h v=1 l=%b b=1",
                           i, out_data30, out_valid30, out_last30, busy30, DW'(i + 1), (i == NB - 1));
      end
      @(posedge clk); #1;
    end
    n_tests++;
    if (out_valid30 !== 1'b0 || busy30 !== 1'b0 || out_last30 !== 1'b0 ||
        mismatch_err30 !== 1'b0 || overrun_err30 !== 1'b0) begin
      n_fail++; $display("FAIL size30_idle: got v=%b b=%b l=%b mis=%b ovr=%b expected all 0",
                         out_valid30, busy30, out_last30, mismatch_err30, overrun_err30);
    end
  endtask

  task automatic test_random();
    logic            r, c;
    logic [N-1:0]    v;
    logic [N*DW-1:0] d;
    int              sel;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 49) == 0);
      c   = ($urandom_range(0, 14) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 3)       v = 4'hF;
      else if (sel == 3) v = 4'($urandom_range(1, 14));
      else               v = 4'h0;
      d = {$urandom, $urandom};
      step(r, d, v, c);
      n_tests++;
      if (obs() !== model_vec()) begin
        n_fail++; $display("FAIL random cycle %0d: got %h expected %h", i, obs(), model_vec());
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, '0, 1'b1);
      n_tests++;
      if (obs() !== model_vec()) begin
        n_fail++; $display("FAIL random_drain %0d: got %h expected %h", i, obs(), model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_overrun();
    test_mismatch();
    test_reset_mid();
    test_default_size();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_out_serializer.md
Name: layer_out_serializer

Overview:
- Sits between two fully connected layers, downstream of a layer's bank of neurons.
- Captures all neuron activation outputs of a layer when they assert their valid together.
- Replays the captured values one per clock as the serial input stream for the next layer's neurons (their data input / input-valid pair).
- Detects misaligned neuron valids and capture overruns.

Parameters:
- numNeurons, 30, number of neurons in the producing layer (>=2)
- dataWidth, 16, width of one activation value

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- in_data  input  numNeurons*dataWidth  concatenated neuron outputs; neuron i at bits [i*dataWidth +: dataWidth]
- in_valid  input  numNeurons  per-neuron output-valid pulses
- err_clear  input  1  clears sticky error flags
- out_data  output  dataWidth  serial activation to next layer
- out_valid  output  1  out_data valid this cycle
- out_last  output  1  high with the final element of a burst
- busy  output  1  burst in progress
- mismatch_err  output  1  sticky: in_valid partially set
- overrun_err  output  1  sticky: capture attempted while busy

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - Synchronous, active-high reset.
  - All outputs are registered.
- Reset values:
  - out_data=0, out_valid=0, out_last=0, busy=0, mismatch_err=0, overrun_err=0.
  - Internal count=0, state=IDLE, buffer contents don't-care.
- Capture event (cap) = &in_valid.
- Partial event = |in_valid & ~&in_valid. It sets mismatch_err at the next edge and performs no capture.
- State IDLE:
  - out_valid=0, out_last=0, busy=0.
  - On an edge with cap: load the buffer from in_data, set out_data<=in_data[element 0], out_valid<=1, busy<=1, count<=0, go SHIFT.
  - Latency: element 0 is on the output the cycle after the capture edge.
- State SHIFT:
  - Each edge advances count and presents element count+1.
  - out_valid stays high for exactly numNeurons consecutive cycles. There are no gaps and no backpressure.
  - out_last=1 only while element numNeurons-1 is presented.
- Leaving SHIFT (edge where the last element is presented):
  - Without cap: out_valid<=0, out_last<=0, busy<=0, out_data holds its last value, go IDLE.
  - With cap: accept it (back-to-back). Reload the buffer, present the new element 0 next cycle, count<=0, stay SHIFT. out_valid is continuous across the two bursts.
- Overrun:
  - A cap at any other SHIFT edge is dropped.
  - overrun_err<=1; the current burst continues unaffected.
- Buffer writes: only on an accepted capture. The buffer must not change mid-burst.
- Error flags:
  - Sticky until err_clear or rst.
  - If err_clear and a new error event occur on the same edge, set wins.
- rst mid-burst: burst aborted immediately; outputs take reset values at that edge. A cap coincident with rst is ignored.
- count width: $clog2(numNeurons). Wrap never occurs because count is reloaded at the last element.
- Data is passed bit-exact with no arithmetic. Signedness is irrelevant.

Test Plan:
- numNeurons=4, dataWidth=16: in_data={16'h0004,16'h0003,16'h0002,16'h0001}, in_valid=4'hF for 1 cycle -> next 4 cycles out_data=1,2,3,4 with out_valid=1; out_last only on 4; busy=1 for those 4 cycles, then all low.
- Back-to-back: second cap (values 5..8) exactly on the edge presenting element 3 -> out_valid high for 8 consecutive cycles, data 1..8, out_last on 4 and 8, no overrun_err.
- Overrun: second cap (values 9..12) on the edge presenting element 1 -> stream stays 1,2,3,4 unchanged; overrun_err=1 from the next cycle until err_clear.
- Mismatch: in_valid=4'b0111 for 1 cycle -> no output burst, mismatch_err=1; err_clear pulse -> 0 next cycle; err_clear coincident with new partial valid -> stays 1.
- Reset mid-burst: rst asserted while element 2 is presented -> next cycle out_valid=0, busy=0, out_data=0; a fresh cap afterwards streams correctly from element 0.
- Default numNeurons=30: 30 incrementing values -> 30 consecutive valid outputs, in order, out_last on the 30th.
